// File: rtl/legv8_pkg.sv
// LEGv8 decode definitions: opcodes, control encodings and ID/EX bundle.
// Shared by decode_stage and register_file.
package legv8_pkg;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    SRC_REG   = 2'b00,
    SRC_SEXT  = 2'b01,
    SRC_IMM12 = 2'b10
  } alu_src_e;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_src_e alu_src;
    alu_op_e  alu_op;
    logic     b;
    logic     bz;
    logic     bnz;
    logic     mem_write;
    logic     mem_read;
    logic     mem_to_reg;
    logic     reg_write;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [63:0] data1;
    logic [63:0] data2;
    ctrl_t       ctrl;
  } id_ex_t;

endpackage

// File: rtl/register_file.sv
// 32x64 LEGv8 register file, X31 reads as zero.
// Define REGFILE_BYPASS_EN for write-through of same-cycle writeback.
module register_file
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [63:0] rdata1,
  output logic [63:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata
);

  logic [63:0] regs_q [32];
  logic [63:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (waddr != XZR);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = (raddr1 == XZR) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == XZR) ? '0 : regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && waddr == raddr1) rdata1 = wdata;
    if (wr_en && waddr == raddr2) rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// LEGv8 decode stage: control decode, operand read, ID/EX register.
// Honours REGFILE_BYPASS_EN through register_file.
module decode_stage
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [63:0] if_pc,
  output logic        if_ready,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_reg,
  input  logic [63:0] wb_data,
  input  logic        mem_pcsrc,
  output logic        ex_valid,
  output logic [63:0] Address,
  output logic [31:0] Instruction,
  output logic [63:0] signExtInstr,
  output logic [63:0] Data1,
  output logic [63:0] Data2,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        B,
  output logic        BZ,
  output logic        BNZ,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal_instr
);

  id_ex_t      ex_q, ex_d;
  logic        illegal_q, illegal_d;
  ctrl_t       ctrl;
  logic [63:0] imm;
  logic [10:0] opc;
  logic [4:0]  rn, rs2, rd_ex;
  logic [63:0] rdata1, rdata2;
  logic        is_r, is_i, is_ld, is_st, is_cb, is_b;
  logic        legal, use1, use2, hazard, accept;

  assign opc = if_instr[31:21];
  assign rn  = if_instr[9:5];

  always_comb begin
    is_r  = opc inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR};
    is_i  = opc[10:1] inside {OPC_ADDI, OPC_SUBI};
    is_ld = (opc == OPC_LDUR);
    is_st = (opc == OPC_STUR);
    is_cb = opc[10:3] inside {OPC_CBZ, OPC_CBNZ};
    is_b  = (opc[10:5] == OPC_B);
  end

  always_comb begin
    ctrl  = '0;
    imm   = '0;
    legal = 1'b1;
    unique case (1'b1)
      is_r: begin
        ctrl.alu_op    = ALUOP_R;
        ctrl.reg_write = 1'b1;
      end
      is_i: begin
        ctrl.alu_src   = SRC_IMM12;
        ctrl.alu_op    = ALUOP_R;
        ctrl.reg_write = 1'b1;
        imm            = {52'd0, if_instr[21:10]};
      end
      is_ld: begin
        ctrl.alu_src    = SRC_SEXT;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        imm = {{55{if_instr[20]}}, if_instr[20:12]};
      end
      is_st: begin
        ctrl.alu_src   = SRC_SEXT;
        ctrl.mem_write = 1'b1;
        imm = {{55{if_instr[20]}}, if_instr[20:12]};
      end
      is_cb: begin
        ctrl.alu_op = ALUOP_BR;
        ctrl.bz     = ~if_instr[24];
        ctrl.bnz    = if_instr[24];
        imm = {{45{if_instr[23]}}, if_instr[23:5]};
      end
      is_b: begin
        ctrl.alu_op = ALUOP_BR;
        ctrl.b      = 1'b1;
        imm = {{38{if_instr[25]}}, if_instr[25:0]};
      end
      default: legal = 1'b0;
    endcase
  end

  assign rs2   = (is_st | is_cb) ? if_instr[4:0] : if_instr[20:16];
  assign use1  = is_r | is_i | is_ld | is_st;
  assign use2  = is_r | is_st | is_cb;
  assign rd_ex = ex_q.instr[4:0];

  // Only sources the instruction really reads can trigger a stall.
  always_comb begin
    hazard = if_valid & ex_q.valid & ex_q.ctrl.mem_read
           & (rd_ex != XZR)
           & ((use1 & (rn == rd_ex)) | (use2 & (rs2 == rd_ex)));
    if_ready = mem_pcsrc | ~hazard;
    accept   = if_valid & if_ready & ~mem_pcsrc;
  end

  register_file u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rn),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_reg_write),
    .waddr  (wb_reg),
    .wdata  (wb_data)
  );

  always_comb begin
    ex_d      = '0;
    illegal_d = illegal_q | (accept & ~legal);
    if (accept & legal) begin
      ex_d.valid = 1'b1;
      ex_d.pc    = if_pc;
      ex_d.instr = if_instr;
      ex_d.imm   = imm;
      ex_d.data1 = rdata1;
      ex_d.data2 = rdata2;
      ex_d.ctrl  = ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign Address       = ex_q.pc;
  assign Instruction   = ex_q.instr;
  assign signExtInstr  = ex_q.imm;
  assign Data1         = ex_q.data1;
  assign Data2         = ex_q.data2;
  assign ALUSrc        = ex_q.ctrl.alu_src;
  assign ALUOp         = ex_q.ctrl.alu_op;
  assign B             = ex_q.ctrl.b;
  assign BZ            = ex_q.ctrl.bz;
  assign BNZ           = ex_q.ctrl.bnz;
  assign MemWrite      = ex_q.ctrl.mem_write;
  assign MemRead       = ex_q.ctrl.mem_read;
  assign MemtoReg      = ex_q.ctrl.mem_to_reg;
  assign RegWrite      = ex_q.ctrl.reg_write;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic        if_ready;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [63:0] wb_data = '0;
  logic        mem_pcsrc = 1'b0;
  logic        ex_valid;
  logic [63:0] Address, signExtInstr, Data1, Data2;
  logic [31:0] Instruction;
  logic [1:0]  ALUSrc, ALUOp;
  logic        B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite;
  logic        illegal_instr;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg),
    .wb_data(wb_data), .mem_pcsrc(mem_pcsrc),
    .ex_valid(ex_valid), .Address(Address),
    .Instruction(Instruction),
    .signExtInstr(signExtInstr),
    .Data1(Data1), .Data2(Data2),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .B(B), .BZ(BZ), .BNZ(BNZ),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal_instr(illegal_instr)
  );

`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  // ctrl bits: {B,BZ,BNZ,MemWrite,MemRead,MemtoReg,RegWrite}
  localparam logic [6:0] K_RW  = 7'b0000001;
  localparam logic [6:0] K_LD  = 7'b0000111;
  localparam logic [6:0] K_ST  = 7'b0001000;
  localparam logic [6:0] K_BNZ = 7'b0010000;
  localparam logic [6:0] K_BZ  = 7'b0100000;
  localparam logic [6:0] K_B   = 7'b1000000;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDR = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [9:0]  ADDI = 10'b1001000100;
  localparam logic [9:0]  SUBI = 10'b1101000100;
  localparam logic [7:0]  CBZ  = 8'b10110100;
  localparam logic [7:0]  CBNZ = 8'b10110101;

  typedef struct {
    logic        v;
    logic [63:0] addr;
    logic [31:0] ins;
    logic [63:0] imm;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        c2;
    logic [1:0]  src;
    logic [1:0]  op;
    logic [6:0]  bits;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic ill_exp = 1'b0;

  task automatic check_eq(input string tag,
                          input logic [63:0] obs,
                          input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{v: 1'b0, addr: '0, ins: '0, imm: '0, d1: '0,
          d2: '0, c2: 1'b1, src: '0, op: '0, bits: '0,
          ill: ill_exp};
    return e;
  endfunction

  function automatic exp_t ie(input logic [63:0] pc,
                              input logic [31:0] ins,
                              input logic [63:0] imm,
                              input logic [63:0] d1,
                              input logic [63:0] d2,
                              input logic        c2,
                              input logic [1:0]  src,
                              input logic [1:0]  op,
                              input logic [6:0]  bits);
    exp_t e;
    e = '{v: 1'b1, addr: pc, ins: ins, imm: imm, d1: d1,
          d2: d2, c2: c2, src: src, op: op, bits: bits,
          ill: ill_exp};
    return e;
  endfunction

  function automatic logic [31:0] rt(input logic [10:0] o,
    input logic [4:0] rm, input logic [4:0] rn,
    input logic [4:0] rd);
    return {o, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] dt(input logic [10:0] o,
    input logic [8:0] im, input logic [4:0] rn,
    input logic [4:0] rd);
    return {o, im, 2'b00, rn, rd};
  endfunction

  function automatic logic [31:0] it(input logic [9:0] o,
    input logic [11:0] im, input logic [4:0] rn,
    input logic [4:0] rd);
    return {o, im, rn, rd};
  endfunction

  function automatic logic [31:0] cb(input logic [7:0] o,
    input logic [18:0] im, input logic [4:0] r);
    return {o, im, r};
  endfunction

  task automatic compare(input string l, input exp_t e);
    logic [6:0] bits;
    bits = {B, BZ, BNZ, MemWrite, MemRead, MemtoReg, RegWrite};
    check_eq({l, ".valid"}, 64'(ex_valid), 64'(e.v));
    check_eq({l, ".addr"}, Address, e.addr);
    check_eq({l, ".instr"}, 64'(Instruction), 64'(e.ins));
    check_eq({l, ".imm"}, signExtInstr, e.imm);
    check_eq({l, ".d1"}, Data1, e.d1);
    if (e.c2) check_eq({l, ".d2"}, Data2, e.d2);
    check_eq({l, ".src"}, 64'(ALUSrc), 64'(e.src));
    check_eq({l, ".op"}, 64'(ALUOp), 64'(e.op));
    check_eq({l, ".ctrl"}, 64'(bits), 64'(e.bits));
    check_eq({l, ".ill"}, 64'(illegal_instr), 64'(e.ill));
  endtask

  task automatic step(input string l, input logic v,
                      input logic [31:0] ins,
                      input logic [63:0] pc,
                      input logic pcsrc, input logic rdy,
                      input exp_t e);
    exp_t got;
    if_valid  = v;
    if_instr  = ins;
    if_pc     = pc;
    mem_pcsrc = pcsrc;
    #1;
    check_eq({l, ".ready"}, 64'(if_ready), 64'(rdy));
    sb.push_back(e);
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
    mem_pcsrc    = 1'b0;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      compare(l, got);
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    wb_reg_write = 1'b1;
    wb_reg       = r;
    wb_data      = d;
    step("wb", 1'b0, '0, '0, 1'b0, 1'b1, bub());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ld4, use4, use4m;
    ld4   = dt(LDUR, 9'd8, 5'd1, 5'd4);
    use4  = rt(ADD, 5'd2, 5'd4, 5'd5);
    use4m = rt(ADD, 5'd4, 5'd2, 5'd5);

    #2;
    compare("rst", bub());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst.ready", 64'(if_ready), 64'd1);
    @(posedge clk);
    #1;

    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    wb(5'd9, 64'h1234);
    wb(5'd31, 64'hAB);

    step("add", 1, rt(ADD, 5'd2, 5'd1, 5'd3), 64'h100,
         0, 1, ie(64'h100, rt(ADD, 5'd2, 5'd1, 5'd3),
         0, 5, 7, 1, 2'b00, 2'b10, K_RW));
    step("sub", 1, rt(SUB, 5'd1, 5'd2, 5'd3), 64'h104,
         0, 1, ie(64'h104, rt(SUB, 5'd1, 5'd2, 5'd3),
         0, 7, 5, 1, 2'b00, 2'b10, K_RW));
    step("and", 1, rt(ANDR, 5'd9, 5'd1, 5'd3), 64'h108,
         0, 1, ie(64'h108, rt(ANDR, 5'd9, 5'd1, 5'd3),
         0, 5, 64'h1234, 1, 2'b00, 2'b10, K_RW));
    step("orr", 1, rt(ORR, 5'd2, 5'd9, 5'd3), 64'h10C,
         0, 1, ie(64'h10C, rt(ORR, 5'd2, 5'd9, 5'd3),
         0, 64'h1234, 7, 1, 2'b00, 2'b10, K_RW));

    // load-use via Rn: one stall cycle, then issue
    step("ldur", 1, ld4, 64'h200, 0, 1,
         ie(64'h200, ld4, 8, 5, 0, 0, 2'b01, 2'b00, K_LD));
    step("stall", 1, use4, 64'h204, 0, 0, bub());
    step("issue", 1, use4, 64'h204, 0, 1,
         ie(64'h204, use4, 0, 0, 7, 1, 2'b00, 2'b10, K_RW));

    // load-use via Rm
    step("ldur2", 1, ld4, 64'h208, 0, 1,
         ie(64'h208, ld4, 8, 5, 0, 0, 2'b01, 2'b00, K_LD));
    step("stall2", 1, use4m, 64'h20C, 0, 0, bub());
    step("issue2", 1, use4m, 64'h20C, 0, 1,
         ie(64'h20C, use4m, 0, 7, 0, 1, 2'b00, 2'b10, K_RW));

    // independent follower and load to XZR do not stall
    step("ldur3", 1, ld4, 64'h210, 0, 1,
         ie(64'h210, ld4, 8, 5, 0, 0, 2'b01, 2'b00, K_LD));
    step("nodep", 1, rt(ADD, 5'd2, 5'd1, 5'd3), 64'h214,
         0, 1, ie(64'h214, rt(ADD, 5'd2, 5'd1, 5'd3),
         0, 5, 7, 1, 2'b00, 2'b10, K_RW));
    step("ldzr", 1, dt(LDUR, 9'd0, 5'd1, 5'd31), 64'h218,
         0, 1, ie(64'h218, dt(LDUR, 9'd0, 5'd1, 5'd31),
         0, 5, 0, 0, 2'b01, 2'b00, K_LD));
    step("zrdep", 1, rt(ADD, 5'd31, 5'd31, 5'd3), 64'h21C,
         0, 1, ie(64'h21C, rt(ADD, 5'd31, 5'd31, 5'd3),
         0, 0, 0, 1, 2'b00, 2'b10, K_RW));

    step("cbz", 1, cb(CBZ, 19'h7FFFD, 5'd9), 64'h300, 0, 1,
         ie(64'h300, cb(CBZ, 19'h7FFFD, 5'd9),
         64'hFFFF_FFFF_FFFF_FFFD, 0, 64'h1234, 1,
         2'b00, 2'b01, K_BZ));
    step("cbnz", 1, cb(CBNZ, 19'd5, 5'd2), 64'h304, 0, 1,
         ie(64'h304, cb(CBNZ, 19'd5, 5'd2),
         5, 0, 7, 1, 2'b00, 2'b01, K_BNZ));
    step("addi", 1, it(ADDI, 12'h7FF, 5'd1, 5'd7), 64'h308,
         0, 1, ie(64'h308, it(ADDI, 12'h7FF, 5'd1, 5'd7),
         64'h7FF, 5, 0, 0, 2'b10, 2'b10, K_RW));
    step("subi", 1, it(SUBI, 12'hFFF, 5'd2, 5'd8), 64'h30C,
         0, 1, ie(64'h30C, it(SUBI, 12'hFFF, 5'd2, 5'd8),
         64'hFFF, 7, 0, 0, 2'b10, 2'b10, K_RW));
    step("stur", 1, dt(STUR, 9'h1FF, 5'd1, 5'd2), 64'h310,
         0, 1, ie(64'h310, dt(STUR, 9'h1FF, 5'd1, 5'd2),
         '1, 5, 7, 1, 2'b01, 2'b00, K_ST));
    step("b", 1, {6'b000101, 26'h3FFFFFE}, 64'h314, 0, 1,
         ie(64'h314, {6'b000101, 26'h3FFFFFE},
         64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0,
         2'b00, 2'b01, K_B));

    // flush wins over a pending load-use stall
    step("ldur4", 1, ld4, 64'h400, 0, 1,
         ie(64'h400, ld4, 8, 5, 0, 0, 2'b01, 2'b00, K_LD));
    step("flush", 1, use4, 64'h404, 1, 1, bub());
    step("postfl", 1, it(ADDI, 12'd3, 5'd1, 5'd7), 64'h408,
         0, 1, ie(64'h408, it(ADDI, 12'd3, 5'd1, 5'd7),
         3, 5, 0, 0, 2'b10, 2'b10, K_RW));
    step("flnop", 1, rt(ADD, 5'd2, 5'd1, 5'd3), 64'h40C,
         1, 1, bub());

    // same-cycle writeback against a read
    wb_reg_write = 1'b1;
    wb_reg = 5'd6;
    wb_data = 64'h11;
    step("byp", 1, rt(ADD, 5'd6, 5'd6, 5'd11), 64'h500,
         0, 1, ie(64'h500, rt(ADD, 5'd6, 5'd6, 5'd11),
         0, BYP ? 64'h11 : 64'h0, BYP ? 64'h11 : 64'h0,
         1, 2'b00, 2'b10, K_RW));
    step("x6", 1, rt(ADD, 5'd6, 5'd6, 5'd11), 64'h504,
         0, 1, ie(64'h504, rt(ADD, 5'd6, 5'd6, 5'd11),
         0, 64'h11, 64'h11, 1, 2'b00, 2'b10, K_RW));
    wb_reg_write = 1'b1;
    wb_reg = 5'd31;
    wb_data = 64'hCD;
    step("bypzr", 1, rt(ADD, 5'd31, 5'd31, 5'd11), 64'h508,
         0, 1, ie(64'h508, rt(ADD, 5'd31, 5'd31, 5'd11),
         0, 0, 0, 1, 2'b00, 2'b10, K_RW));

    ill_exp = 1'b1;
    step("ill", 1, 32'hFFFF_FFFF, 64'h600, 0, 1, bub());
    step("sticky", 1, rt(ADD, 5'd2, 5'd1, 5'd3), 64'h604,
         0, 1, ie(64'h604, rt(ADD, 5'd2, 5'd1, 5'd3),
         0, 5, 7, 1, 2'b00, 2'b10, K_RW));

    // asynchronous reset mid-cycle
    if_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    ill_exp = 1'b0;
    #1;
    compare("arst", bub());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rfclr", 1, rt(ADD, 5'd2, 5'd1, 5'd3), 64'h700,
         0, 1, ie(64'h700, rt(ADD, 5'd2, 5'd1, 5'd3),
         0, 0, 0, 1, 2'b00, 2'b10, K_RW));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
